// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer that time-shares one ALU32 between two requesters.
// Optional macro ALU_SHARE_ILLEGAL_OP_EN: illegal opcodes bypass the ALU and return rsp_err.
module alu_share_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_of,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_of,
  output logic            rsp_zero,
  output logic            rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;

  // Handshakes: a request transfers on the rising edge where reqN_valid && reqN_ready;
  // the response transfers where rsp_valid && rsp_ready, and rsp_* hold until then.

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            id_q, id_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] alu_in0_q, alu_in0_d;
  logic [XLEN-1:0] alu_in1_q, alu_in1_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_of_q, rsp_of_d;
  logic            rsp_zero_q, rsp_zero_d;

  logic            grant0, grant1;
  logic            accept;
  logic            acc_id;
  logic [3:0]      acc_op;
  logic [XLEN-1:0] acc_a, acc_b;
  logic            acc_illegal;

  // Both valid: the pointer picks; a lone requester always wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~ptr_q);
    grant1 = req1_valid & (~req0_valid |  ptr_q);
  end

  always_comb begin
    accept = req0_ready | req1_ready;
    acc_id = req1_ready;
    acc_op = req1_ready ? req1_op : req0_op;
    acc_a  = req1_ready ? req1_a  : req0_a;
    acc_b  = req1_ready ? req1_b  : req0_b;
  end

`ifdef ALU_SHARE_ILLEGAL_OP_EN
  logic rsp_err_q, rsp_err_d;

  always_comb begin
    case (acc_op)
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1100, 4'b1101: acc_illegal = 1'b0;
      default:                            acc_illegal = 1'b1;
    endcase
  end
`else
  always_comb acc_illegal = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = acc_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req0_ready = (state_q == ST_IDLE) & grant0 & ~rst;
    req1_ready = (state_q == ST_IDLE) & grant1 & ~rst;
  end

  always_comb begin
    ptr_d       = ptr_q;
    id_d        = id_q;
    alu_op_d    = alu_op_q;
    alu_in0_d   = alu_in0_q;
    alu_in1_d   = alu_in1_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_of_d    = rsp_of_q;
    rsp_zero_d  = rsp_zero_q;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ptr_d = ~acc_id;
          id_d  = acc_id;
          if (acc_illegal) begin
            // Illegal op: answer immediately, leaving the ALU inputs untouched.
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_of_d    = 1'b0;
            rsp_zero_d  = 1'b0;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
            rsp_err_d   = 1'b1;
`endif
          end else begin
            alu_op_d  = acc_op;
            alu_in0_d = acc_a;
            alu_in1_d = acc_b;
          end
        end
      end
      ST_EXEC: begin
        // Flags are qualified by opcode; zero is only meaningful for a compare/subtract.
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_of_d    = alu_of & ((alu_op_q == OP_ADD) | (alu_op_q == OP_SUB));
        rsp_zero_d  = (alu_op_q == OP_SUB) & (alu_out == '0);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
        rsp_err_d   = 1'b0;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      alu_op_q    <= 4'b0000;
      alu_in0_q   <= '0;
      alu_in1_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_of_q    <= 1'b0;
      rsp_zero_q  <= 1'b0;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      alu_op_q    <= alu_op_d;
      alu_in0_q   <= alu_in0_d;
      alu_in1_q   <= alu_in1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_of_q    <= rsp_of_d;
      rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_in0   = alu_in0_q;
  assign alu_in1   = alu_in1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_zero  = rsp_zero_q;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: transaction-level reference model plus directed literal checks.
// Honours ALU_SHARE_ILLEGAL_OP_EN the same way the design does.
module tb_alu_share_arb;
  localparam int XLEN = 32;
  localparam int RW   = XLEN + 4;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid;
  logic            req0_ready, req1_ready;
  logic [3:0]      req0_op, req1_op;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [XLEN-1:0] alu_in0, alu_in1, alu_out;
  logic [3:0]      alu_op;
  logic            alu_of;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_of, rsp_zero, rsp_err;
  logic [XLEN-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  alu_share_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_of(rsp_of), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU32 stand-in: {of_detect, result}. Non add/sub ops raise of_detect too, so masking matters.
  function automatic logic [XLEN:0] alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      4'h1:    return {1'b0, a & b};
      4'h2:    return {1'b0, a | b};
      4'h3:    return {1'b0, a ^ b};
      4'h4:    return {1'b0, a} + {1'b0, b};
      4'h5:    return {(a < b), a - b};
      4'h6:    return {b[0], a << b[4:0]};
      4'h7:    return {a[XLEN-1], a >> b[4:0]};
      default: return {a[0] ^ b[0], a ^ {b[15:0], b[31:16]}};
    endcase
  endfunction

  assign {alu_of, alu_out} = alu_ref(alu_op, alu_in0, alu_in1);

  function automatic logic is_illegal(input logic [3:0] op);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    return !((op >= 4'd1 && op <= 4'd9) || op == 4'd12 || op == 4'd13);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [RW-1:0] mk(input logic err, input logic id, input logic of, input logic zero, input logic [XLEN-1:0] data);
    return {err, id, of, zero, data};
  endfunction

  function automatic logic [RW-1:0] exp_rsp(input logic id, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN:0] r;
    r = alu_ref(op, a, b);
    if (is_illegal(op)) return mk(1'b1, id, 1'b0, 1'b0, '0);
    return mk(1'b0, id, (op == 4'd4 || op == 4'd5) ? r[XLEN] : 1'b0,
              (op == 4'd5) && (r[XLEN-1:0] == '0), r[XLEN-1:0]);
  endfunction

  // 0 = nobody, 1 = port 0, 2 = port 1
  function automatic logic [1:0] pick(input logic v0, input logic v1, input logic p);
    if (v0 && v1) return p ? 2'd2 : 2'd1;
    if (v0) return 2'd1;
    if (v1) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus queues and the reference model state
  req_t             q0[$], q1[$];
  logic [RW-1:0]    exp_q[$];
  logic [RW-1:0]    act_log[$];
  int               acc_log[$], rise_log[$];
  int               cyc = 0, cnt_r0 = 0, m_age = 0, m_wait = 1;
  logic             m_ptr = 1'b0;
  logic [3:0]       m_op = '0;
  logic [XLEN-1:0]  m_a = '0, m_b = '0;
  int               rdy_mode = 0;
  logic             prev_rv = 1'b0;

  // Model: one outstanding transaction; response visible m_wait edges after accept.
  always @(posedge clk) begin
    logic [1:0]      g;
    logic            id;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b;
    cyc++;
    if (rsp_valid && rsp_ready && !rst) act_log.push_back(mk(rsp_err, rsp_id, rsp_of, rsp_zero, rsp_data));
    if (rst) begin
      exp_q.delete();
      m_age = 0; m_ptr = 1'b0; m_op = '0; m_a = '0; m_b = '0;
    end else if (exp_q.size() > 0) begin
      if (m_age >= m_wait) begin
        if (rsp_ready) exp_q.delete(0);
      end else begin
        m_age++;
      end
    end else begin
      g = pick(req0_valid, req1_valid, m_ptr);
      if (g != 2'd0) begin
        id = (g == 2'd2);
        op = id ? req1_op : req0_op;
        a  = id ? req1_a  : req0_a;
        b  = id ? req1_b  : req0_b;
        exp_q.push_back(exp_rsp(id, op, a, b));
        m_age  = 0;
        m_wait = is_illegal(op) ? 0 : 1;
        if (!is_illegal(op)) begin m_op = op; m_a = a; m_b = b; end
        m_ptr = ~id;
        if (id && q1.size() > 0) q1.delete(0);
        if (!id && q0.size() > 0) q0.delete(0);
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [1:0] g;
    logic       e_rv;
    g = pick(req0_valid, req1_valid, m_ptr);
    chk("req0_ready", req0_ready, !rst && exp_q.size() == 0 && g == 2'd1);
    chk("req1_ready", req1_ready, !rst && exp_q.size() == 0 && g == 2'd2);
    e_rv = exp_q.size() > 0 && m_age >= m_wait;
    chk("rsp_valid", rsp_valid, e_rv);
    if (e_rv) chk("rsp_fields", mk(rsp_err, rsp_id, rsp_of, rsp_zero, rsp_data), exp_q[0]);
    chk("alu_op", alu_op, m_op);
    chk("alu_in0", alu_in0, m_a);
    chk("alu_in1", alu_in1, m_b);
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_log.push_back(cyc);
    if (req0_ready) cnt_r0++;
    if (rsp_valid && !prev_rv) rise_log.push_back(cyc);
    prev_rv = rsp_valid;
  end

  // Driver: present the head of each port queue, never looking at ready
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(posedge clk); #1;
      req0_valid = q0.size() > 0;
      if (q0.size() > 0) {req0_op, req0_a, req0_b} = q0[0];
      req1_valid = q1.size() > 0;
      if (q1.size() > 0) {req1_op, req1_a, req1_b} = q1[0];
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = $urandom_range(0, 3) != 0;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic push_req(input int port, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (port == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, limit %0d", n, budget);
      q0.delete(); q1.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] last_rsp(input int back);
    int idx;
    idx = act_log.size() - 1 - back;
    if (idx < 0) return '1;
    return act_log[idx];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int k, n_before, r0_before;
    logic [RW-1:0] r;
    rst = 1'b1;
    // Both ports queued while reset is held: no ready may rise during reset
    push_req(0, 4'h5, 32'd9, 32'd9);
    push_req(1, 4'h1, 32'hF0, 32'h3C);
    repeat (3) @(negedge clk);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_op", alu_op, 4'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Both valid from reset: port 0 first, port 1 three cycles later
    wait_idle(40);
    chk("both_first", last_rsp(1), mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0));
    chk("both_second", last_rsp(0), mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h30));
    chk("both_interval", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 3);
    push_req(0, 4'h2, 32'h1, 32'h2);
    push_req(1, 4'h3, 32'h5, 32'h6);
    wait_idle(40);
    r = last_rsp(1);
    chk("rr_first_id", r[XLEN+2], 1'b0);
    r = last_rsp(0);
    chk("rr_second_id", r[XLEN+2], 1'b1);

    // Port 0 alone: add 5+7
    r0_before = cnt_r0;
    push_req(0, 4'h4, 32'd5, 32'd7);
    wait_idle(40);
    chk("add_rsp", last_rsp(0), mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd12));
    chk("add_latency", rise_log[rise_log.size()-1] - acc_log[acc_log.size()-1], 2);
    chk("add_ready_cycles", cnt_r0 - r0_before, 1);

    // Add carry-out raises overflow, zero stays low
    push_req(0, 4'h4, 32'hFFFF_FFFF, 32'd1);
    wait_idle(40);
    chk("add_of", last_rsp(0), mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0));

    // Backpressure: response held 5 cycles while port 1 waits
    rdy_mode = 2;
    push_req(0, 4'h4, 32'd100, 32'd23);
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    chk("hold_valid", rsp_valid, 1'b1);
    push_req(1, 4'h1, 32'hFF, 32'h0F);
    repeat (5) begin
      @(negedge clk);
      chk("hold_data", rsp_data, 32'd123);
      chk("hold_req1_ready", req1_ready, 1'b0);
    end
    rdy_mode = 0;
    wait_idle(40);
    chk("hold_port1", last_rsp(0), mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0F));

    // Reset while the request sits in EXEC: it must never answer
    n_before = act_log.size();
    push_req(0, 4'h4, 32'hAAAA, 32'd1);
    k = 0;
    while (!(req0_valid && req0_ready) && k < 20) begin @(negedge clk); k++; end
    chk("abort_accept", req0_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    repeat (8) @(posedge clk);
    chk("abort_no_rsp", act_log.size() - n_before, 0);
    push_req(0, 4'h3, 32'hF, 32'h3);
    push_req(1, 4'h2, 32'h10, 32'h1);
    wait_idle(40);
    r = last_rsp(1);
    chk("abort_ptr_reset", r[XLEN+2], 1'b0);

    // Undefined opcode 1110 after a legal op
    push_req(0, 4'h2, 32'h1, 32'h2);
    push_req(0, 4'hE, 32'h1234, 32'h5678);
    wait_idle(40);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    chk("illegal_rsp", last_rsp(0), mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
    chk("illegal_latency", rise_log[rise_log.size()-1] - acc_log[acc_log.size()-1], 1);
    chk("illegal_alu_op", alu_op, 4'h2);
`else
    chk("undef_rsp", last_rsp(0), mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h5678_1234));
    chk("undef_latency", rise_log[rise_log.size()-1] - acc_log[acc_log.size()-1], 2);
    chk("undef_alu_op", alu_op, 4'hE);
`endif

    // Randomised traffic with random backpressure
    rdy_mode = 1;
    repeat (300) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1 && (p == 0 ? q0.size() : q1.size()) < 3) begin
          logic [XLEN-1:0] a, b;
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? a : $urandom;
          push_req(p, 4'($urandom_range(0, 15)), a, b);
        end
      end
      @(posedge clk); #1;
    end
    wait_idle(3000);
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that time-shares one ALU32 instance between two requesters, e.g. the execute stage (port 0) and the branch-compare unit (port 1). Grants one request at a time using round-robin priority and registers operands and opcode into the ALU. It captures the result and flags, then returns them on a single tagged response channel with backpressure. It sits between the decode/execute logic and the ALU and owns every ALU input.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width; must match ALU32.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: request present on port 0 / 1.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_op` / `req1_op` in 4: ALU opcode.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in XLEN: operands.
- `alu_in0`, `alu_in1` out XLEN: registered operands driven to ALU32.
- `alu_op` out 4: registered opcode driven to ALU32.
- `alu_out` in XLEN: ALU32 result.
- `alu_of` in 1: ALU32 of_detect.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: port that issued the request.
- `rsp_data` out XLEN: captured result.
- `rsp_of` out 1: overflow flag.
- `rsp_zero` out 1: zero flag.
- `rsp_err` out 1: illegal opcode flag (macro only; tied 0 otherwise).

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: ALU inputs are stable for one full cycle.
  - RESP: `rsp_valid` is high, waiting for `rsp_ready`.
- IDLE: the grant is computed combinationally from the valids and the priority pointer `ptr`.
  - Only one valid: that port wins.
  - Both valid: port `ptr` wins.
  - `reqN_ready` = (state==IDLE) & grantN. At most one ready is high per cycle.
- Accept when `reqN_valid` & `reqN_ready`:
  - Latch op/a/b into `alu_op`/`alu_in0`/`alu_in1` and latch id = N.
  - Set `ptr` = ~N.
  - Go to EXEC.
- EXEC, unconditionally:
  - Capture `rsp_data` = `alu_out`.
  - `rsp_of` = `alu_of` if op ∈ {0100, 0101}, else 0.
  - `rsp_zero` = (`alu_out`==0) if op==0101, else 0. It is computed here, not taken from ALU32.
  - Go to RESP.
- RESP: hold all `rsp_*` stable while `rsp_ready`=0. On `rsp_ready`=1, go to IDLE.
- No new request is accepted in EXEC or RESP (no overlap). A pending requester keeps `valid` high and is served next.
- `ptr` changes only on accept, so a lone requester is never starved or delayed.
- `alu_op`/`alu_in0`/`alu_in1` keep their last values when idle.
- Reset values:
  - state = IDLE, `ptr` = 0.
  - `alu_op` = 0000, `alu_in0` = `alu_in1` = 0.
  - `rsp_valid` = `rsp_id` = `rsp_of` = `rsp_zero` = `rsp_err` = 0, `rsp_data` = 0.
  - `req*_ready` = 0 during the reset cycle.
- Reset mid-operation (EXEC or RESP): the in-flight request and its response are discarded, and everything returns to reset values on the next edge.

## Timing
- Request accepted at edge N: ALU inputs are valid after N, result captured at N+1, `rsp_valid` high after N+1. Accept-to-response latency is 2 cycles.
- Minimum accept-to-next-accept interval is 3 cycles:
  - Response consumed in the same cycle `rsp_valid` rises: IDLE after N+2, next accept at N+3.
- `req*_ready` depends combinationally on `req*_valid`. Requesters must not derive `valid` from `ready`.
- The response path (`rsp_*`) is fully registered.

## Configuration
- `ALU_SHARE_ILLEGAL_OP_EN` defined:
  - Legal opcodes are 0001–0111, 1000, 1001, 1100, 1101.
  - An accepted request with any other opcode skips EXEC. The FSM goes directly to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_of`=0, `rsp_zero`=0.
  - `alu_*` registers are not updated. Latency is 1 cycle.
- Macro undefined:
  - `rsp_err` is tied to 0.
  - Every opcode follows the normal EXEC path; ALU32 output for an undefined op passes through as captured.

## Test plan
- Port 0 alone, op=0100, a=5, b=7 → `req0_ready`=1 for 1 cycle; 2 cycles later `rsp_valid`=1, `rsp_id`=0, `rsp_data`=12, `rsp_of`=0, `rsp_zero`=0.
- Both valid from reset, port 0 op=0101, 9−9; port 1 op=0001, 0xF0&0x3C → port 0 served first (`rsp_zero`=1). Port 1 is then accepted 3 cycles after port 0, `rsp_data`=0x30, `rsp_id`=1. Repeat with both valid: port 0 wins again (`ptr` alternates).
- op=0100, a=0xFFFFFFFF, b=1 → `rsp_data`=0, `rsp_of`=1, `rsp_zero`=0 (not a subtract).
- Hold `rsp_ready`=0 for 5 cycles with port 1 valid → `rsp_*` stable, `req1_ready`=0 throughout. Port 1 is accepted the cycle after `rsp_ready`=1 returns the FSM to IDLE.
- Assert `rst` during EXEC → next cycle `rsp_valid`=0, state IDLE, `ptr`=0, no response for the aborted request ever appears.
- With `ALU_SHARE_ILLEGAL_OP_EN`, op=1110 → `rsp_valid` 1 cycle after accept with `rsp_err`=1, `rsp_data`=0, `alu_op` unchanged. Without the macro, the same op gives `rsp_err`=0 and a 2-cycle latency.
